// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared types for the mesh router: flit layout, flit types, input-port FSM
// states, output-port route encodings and the XY (dimension-ordered) routing
// function used by each input port.
// ---------------------------------------------------------------------------
package router_pkg;

    typedef enum logic [1:0] {
        NONE_FLIT = 2'd0,
        HEAD_FLIT = 2'd1,
        BODY_FLIT = 2'd2,
        TAIL_FLIT = 2'd3
    } FLIT_TYPE_t;

    // 19-bit flit. Body/tail flits reuse the address fields as payload.
    typedef struct packed {
        logic       valid;
        FLIT_TYPE_t flit_type;
        logic [7:0] xaddr;
        logic [7:0] yaddr;
    } FLIT_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTING = 2'd1,
        WAITING = 2'd2,
        ACTIVE  = 2'd3
    } GLOBAL_STATE_t;

    typedef enum logic [2:0] {
        ROUTE_NORTH = 3'd0,
        ROUTE_EAST  = 3'd1,
        ROUTE_SOUTH = 3'd2,
        ROUTE_WEST  = 3'd3,
        ROUTE_LOCAL = 3'd4
    } ROUTE_t;

    localparam int FLIT_W = $bits(FLIT_t);

    // X dimension is resolved first; Y only once the column matches.
    function automatic ROUTE_t xy_route(input logic [7:0] xaddr,
                                        input logic [7:0] yaddr,
                                        input logic [7:0] cur_x,
                                        input logic [7:0] cur_y);
        if (xaddr > cur_x)      return ROUTE_EAST;
        else if (xaddr < cur_x) return ROUTE_WEST;
        else if (yaddr > cur_y) return ROUTE_NORTH;
        else if (yaddr < cur_y) return ROUTE_SOUTH;
        else                    return ROUTE_LOCAL;
    endfunction

endpackage

// File: rtl/router_flit_fifo.sv
// ---------------------------------------------------------------------------
// router_flit_fifo
// Synchronous flit FIFO with show-ahead read (o_data is the current front).
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset (empties the FIFO)
//   i_push     write i_data at the tail (ignored when full)
//   i_data     flit to write
//   i_pop      advance the front (ignored when empty)
//   o_data     front flit, meaningful only when !o_empty
//   o_full     no free slot
//   o_empty    no stored flit
// ---------------------------------------------------------------------------
module router_flit_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_push,
    input  FLIT_t i_data,
    input  logic  i_pop,
    output FLIT_t o_data,
    output logic  o_full,
    output logic  o_empty
);

    localparam int AW = $clog2(DEPTH);

    FLIT_t       r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_push;
    logic        w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only observed behind the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/router_input_port.sv
// ---------------------------------------------------------------------------
// router_input_port
// Ingress stage of one mesh-router port. Buffers link flits, computes the XY
// route of each head flit, requests the crossbar and streams the packet out.
// Stray body/tail flits seen while idle and valid NONE flits are discarded
// and counted.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_flit     upstream flit (in_flit.valid qualifies)
//   in_ready    FIFO not full; accepted when in_flit.valid && in_ready
//   sw_req      crossbar request, held until sw_ack
//   sw_route    requested output port, stable while sw_req
//   sw_ack      crossbar grant
//   out_flit    flit to crossbar (all-zero unless ACTIVE with data)
//   out_ready   crossbar takes out_flit this cycle
//   gstate      current FSM state
//   drop_cnt    saturating count of discarded flits
// ---------------------------------------------------------------------------
module router_input_port
    import router_pkg::*;
#(
    parameter logic [7:0] ROUTER_X   = 8'd0,
    parameter logic [7:0] ROUTER_Y   = 8'd0,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  FLIT_t         in_flit,
    output logic          in_ready,
    output logic          sw_req,
    output ROUTE_t        sw_route,
    input  logic          sw_ack,
    output FLIT_t         out_flit,
    input  logic          out_ready,
    output GLOBAL_STATE_t gstate,
    output logic [7:0]    drop_cnt
);

    GLOBAL_STATE_t r_state;
    GLOBAL_STATE_t w_next;
    ROUTE_t        r_route;
    logic [7:0]    r_drop_cnt;
    logic [8:0]    w_drop_sum;

    FLIT_t w_front;
    logic  w_full;
    logic  w_empty;
    logic  w_push;
    logic  w_pop;
    logic  w_in_drop;
    logic  w_fifo_drop;

    assign in_ready  = !w_full;
    assign w_push    = in_flit.valid && in_ready && (in_flit.flit_type != NONE_FLIT);
    assign w_in_drop = in_flit.valid && in_ready && (in_flit.flit_type == NONE_FLIT);

    router_flit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (in_flit),
        .i_pop   (w_pop),
        .o_data  (w_front),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_fifo_drop = 1'b0;
        sw_req      = 1'b0;
        out_flit    = '0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    if (w_front.flit_type == HEAD_FLIT) begin
                        w_next = ROUTING;
                    end else begin
                        // orphan body/tail with no head in front of it
                        w_pop       = 1'b1;
                        w_fifo_drop = 1'b1;
                    end
                end
            end
            ROUTING: w_next = WAITING;
            WAITING: begin
                sw_req = 1'b1;
                if (sw_ack) w_next = ACTIVE;
            end
            ACTIVE: begin
                if (!w_empty) begin
                    out_flit       = w_front;
                    out_flit.valid = 1'b1;
                    if (out_ready) begin
                        w_pop = 1'b1;
                        if (w_front.flit_type == TAIL_FLIT) w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Head is still at the FIFO front during ROUTING (nothing pops there).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_route <= ROUTE_NORTH;
        else if (r_state == ROUTING) r_route <= xy_route(w_front.xaddr, w_front.yaddr,
                                                         ROUTER_X, ROUTER_Y);
    end

    // An ingress NONE drop and an orphan pop can coincide, hence +0..+2.
    assign w_drop_sum = {1'b0, r_drop_cnt} + {8'd0, w_in_drop} + {8'd0, w_fifo_drop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_drop_cnt <= '0;
        else if (w_drop_sum[8])  r_drop_cnt <= 8'hFF;
        else                     r_drop_cnt <= w_drop_sum[7:0];
    end

    assign sw_route = r_route;
    assign gstate   = r_state;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_router_input_port.sv
module tb_router_input_port;
    import router_pkg::*;

    localparam logic [7:0] RX = 8'd2;
    localparam logic [7:0] RY = 8'd2;

    logic          clk = 1'b0;
    logic          rst;
    FLIT_t         in_flit;
    logic          in_ready;
    logic          sw_req;
    ROUTE_t        sw_route;
    logic          sw_ack;
    FLIT_t         out_flit;
    logic          out_ready;
    GLOBAL_STATE_t gstate;
    logic [7:0]    drop_cnt;

    router_input_port #(.ROUTER_X(RX), .ROUTER_Y(RY), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .sw_req    (sw_req),
        .sw_route  (sw_route),
        .sw_ack    (sw_ack),
        .out_flit  (out_flit),
        .out_ready (out_ready),
        .gstate    (gstate),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model (packet-level view of the stream)
    FLIT_t exp_q[$];
    int    exp_route_q[$];
    int    route_log[$];
    bit    m_in_pkt;
    int    m_drop;
    int    acc_cnt, req_cnt;
    int    head_acc_cyc, head_out_cyc, tail_out_cyc;
    bit    prev_wait;
    int    prev_route;
    bit    rnd_en;

    function automatic int ref_route(input logic [7:0] x, input logic [7:0] y);
        int dx = int'(x) - int'(RX);
        int dy = int'(y) - int'(RY);
        if (dx > 0) return 1;
        if (dx < 0) return 3;
        if (dy > 0) return 0;
        if (dy < 0) return 2;
        return 4;
    endfunction

    function automatic FLIT_t mk(input FLIT_TYPE_t t, input logic [7:0] x, input logic [7:0] y);
        FLIT_t f;
        f.valid = 1'b1; f.flit_type = t; f.xaddr = x; f.yaddr = y;
        return f;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: sample everything mid-cycle, away from the rising edge.
    initial forever begin
        FLIT_t e;
        @(negedge clk);
        if (rst) begin
            exp_q.delete(); exp_route_q.delete();
            m_in_pkt = 0; m_drop = 0; prev_wait = 0;
        end else begin
            if (in_flit.valid && in_ready) begin
                acc_cnt++;
                if (in_flit.flit_type == NONE_FLIT) begin
                    if (m_drop < 255) m_drop++;
                end else if (!m_in_pkt) begin
                    if (in_flit.flit_type == HEAD_FLIT) begin
                        exp_q.push_back(in_flit);
                        exp_route_q.push_back(ref_route(in_flit.xaddr, in_flit.yaddr));
                        m_in_pkt = 1;
                        head_acc_cyc = cyc;
                    end else if (m_drop < 255) m_drop++;
                end else begin
                    exp_q.push_back(in_flit);
                    if (in_flit.flit_type == TAIL_FLIT) m_in_pkt = 0;
                end
            end
            if (out_flit.valid && out_ready) begin
                if (exp_q.size() == 0) chk("out_extra", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("out_flit", out_flit, e);
                    if (e.flit_type == HEAD_FLIT) head_out_cyc = cyc;
                    if (e.flit_type == TAIL_FLIT) tail_out_cyc = cyc;
                end
            end
            if (gstate != ACTIVE) chk("out_zero_idle", out_flit, 0);
            if (prev_wait) begin
                chk("req_hold", sw_req, 1);
                chk("route_hold", sw_route, prev_route);
            end
            if (sw_req) req_cnt++;
            if (sw_req && sw_ack) begin
                if (exp_route_q.size() == 0) chk("route_extra", exp_route_q.size(), 1);
                else chk("sw_route", sw_route, exp_route_q.pop_front());
                route_log.push_back(int'(sw_route));
            end
            prev_wait  = sw_req && !sw_ack;
            prev_route = int'(sw_route);
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_en) begin
            out_ready = ($urandom % 4) != 0;
            sw_ack    = ($urandom % 3) == 0;
        end
    endtask

    task automatic send(input FLIT_t f);
        bit acc;
        int n = 0;
        in_flit = f;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 300);
        if (!acc) chk("send_timeout", acc, 1);
        in_flit = '0;
    endtask

    task automatic drain();
        int n = 0;
        in_flit = '0;
        while ((exp_q.size() != 0 || gstate != IDLE) && n < 3000) begin
            tick();
            n++;
        end
        repeat (12) tick();
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_idle", gstate, IDLE);
    endtask

    int          a0, r0, rl0, n;
    int          dst_x[4] = '{2, 0, 2, 2};
    int          dst_y[4] = '{2, 9, 0, 7};
    int          exp_r[4] = '{4, 3, 2, 0};
    logic [7:0]  rx, ry;
    FLIT_TYPE_t  st;

    initial begin
        rst = 1'b1; in_flit = '0; sw_ack = 1'b0; out_ready = 1'b0; rnd_en = 0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sw_req", sw_req, 0);
        chk("rst_sw_route", sw_route, 0);
        chk("rst_out_flit", out_flit, 0);
        chk("rst_gstate", gstate, IDLE);
        chk("rst_drop_cnt", drop_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;

        // orphan body, orphan tail, NONE flit: all discarded, no request
        sw_ack = 1'b1; out_ready = 1'b1;
        r0 = req_cnt;
        send(mk(BODY_FLIT, 8'h11, 8'h22));
        send(mk(TAIL_FLIT, 8'h33, 8'h44));
        send(mk(NONE_FLIT, 8'h55, 8'h66));
        repeat (6) tick();
        chk("drop_cnt_3", drop_cnt, 3);
        chk("drop_no_req", req_cnt - r0, 0);
        chk("drop_idle", gstate, IDLE);

        // back-to-back 4-flit packet heading east
        send(mk(HEAD_FLIT, 8'd5, 8'd1));
        send(mk(BODY_FLIT, 8'hA1, 8'h01));
        send(mk(BODY_FLIT, 8'hA2, 8'h02));
        send(mk(TAIL_FLIT, 8'hA3, 8'h03));
        drain();
        chk("t1_route_east", route_log[route_log.size()-1], 1);
        chk("t1_head_latency", head_out_cyc - head_acc_cyc, 4);
        chk("t1_burst", tail_out_cyc - head_out_cyc, 3);

        // route directions
        rl0 = route_log.size();
        for (int i = 0; i < 4; i++) begin
            send(mk(HEAD_FLIT, 8'(dst_x[i]), 8'(dst_y[i])));
            send(mk(TAIL_FLIT, 8'h00, 8'h00));
        end
        drain();
        for (int i = 0; i < 4; i++)
            chk($sformatf("route_dir%0d", i), route_log[rl0+i], exp_r[i]);

        // grant withheld: request held, FIFO fills, 9th flit backs up
        sw_ack = 1'b0;
        a0 = acc_cnt;
        send(mk(HEAD_FLIT, 8'd5, 8'd1));
        for (int i = 0; i < 7; i++) send(mk(BODY_FLIT, 8'(i), 8'(i)));
        in_flit = mk(TAIL_FLIT, 8'hEE, 8'hEE);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_req", sw_req, 1);
            chk("stall_route", sw_route, 1);
            chk("stall_out_valid", out_flit.valid, 0);
            chk("stall_in_ready", in_ready, 0);
            tick();
        end
        chk("stall_acc8", acc_cnt - a0, 8);
        sw_ack = 1'b1;
        send(mk(TAIL_FLIT, 8'hEE, 8'hEE));
        drain();

        // randomized traffic with back-pressure, grant delay and gaps
        rnd_en = 1;
        for (int p = 0; p < 30; p++) begin
            if ($urandom % 5 == 0) begin
                st = ($urandom % 2) ? BODY_FLIT : TAIL_FLIT;
                send(mk(st, 8'($urandom), 8'($urandom)));
            end
            if ($urandom % 5 == 0) send(mk(NONE_FLIT, 8'($urandom), 8'($urandom)));
            rx = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
            ry = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
            send(mk(HEAD_FLIT, rx, ry));
            n = $urandom_range(0, 4);
            for (int b = 0; b < n; b++) begin
                if ($urandom % 3 == 0) begin in_flit = '0; tick(); end
                send(mk(BODY_FLIT, 8'($urandom), 8'($urandom)));
            end
            send(mk(TAIL_FLIT, 8'($urandom), 8'($urandom)));
        end
        drain();
        rnd_en = 0; out_ready = 1'b1; sw_ack = 1'b1;
        chk("rand_drop_cnt", drop_cnt, m_drop);

        // reset while ACTIVE with two bodies still buffered
        out_ready = 1'b0;
        send(mk(HEAD_FLIT, 8'd0, 8'd0));
        send(mk(BODY_FLIT, 8'h01, 8'h01));
        send(mk(BODY_FLIT, 8'h02, 8'h02));
        n = 0;
        while (gstate != ACTIVE && n < 50) begin tick(); n++; end
        chk("t5_active", gstate, ACTIVE);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_in_ready", in_ready, 1);
        chk("t5_sw_req", sw_req, 0);
        chk("t5_sw_route", sw_route, 0);
        chk("t5_out_flit", out_flit, 0);
        chk("t5_gstate", gstate, IDLE);
        chk("t5_drop_cnt", drop_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1; sw_ack = 1'b1;
        send(mk(HEAD_FLIT, 8'd2, 8'd7));
        send(mk(TAIL_FLIT, 8'h77, 8'h77));
        drain();
        chk("t5_route_after", route_log[route_log.size()-1], 0);
        chk("t5_drop_after", drop_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/router_input_port.md
# router_input_port

Per-port ingress stage of the mesh router: accepts 19-bit flits from the link, buffers them in a flit FIFO, computes the XY output route from each head flit, arbitrates for the crossbar with a switch_req/switch_ack handshake, then streams the packet (head, bodies, tail) to the switch stage. One instance per input port; its output feeds the crossbar/switch allocator.

## Interface
Parameters:
- ROUTER_X, 0, this router's X coordinate (8-bit value)
- ROUTER_Y, 0, this router's Y coordinate (8-bit value)
- FIFO_DEPTH, 8, flit slots; power of 2, ≥ NUM_OF_FLITS

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_flit  in  FLIT_t (19)  upstream flit; in_flit.valid qualifies it
- in_ready  out  1  FIFO not full; flit accepted when in_flit.valid && in_ready
- sw_req  out  1  crossbar request, held until acked
- sw_route  out  ROUTE_t (3)  requested output port, stable while sw_req=1
- sw_ack  in  1  grant, sampled only while sw_req=1
- out_flit  out  FLIT_t (19)  flit to crossbar; out_flit.valid qualifies it
- out_ready  in  1  crossbar accepts out_flit this cycle
- gstate  out  GLOBAL_STATE_t (2)  current FSM state
- drop_cnt  out  8  saturating count of discarded flits

## Operation
- Ingress: valid flit with flit_type ≠ NONE_FLIT and in_ready=1 is written at FIFO tail. Valid NONE_FLIT is accepted (consumes handshake), not stored, drop_cnt+1. in_ready = !full (no dependence on same-cycle pop).
- Route (XY, X first), dst from head.xaddr/yaddr, unsigned compare: xaddr>ROUTER_X → EAST(1); xaddr<ROUTER_X → WEST(3); else yaddr>ROUTER_Y → NORTH(0); yaddr<ROUTER_Y → SOUTH(2); else LOCAL(4).
- FSM:
  - IDLE: FIFO front is HEAD_FLIT → ROUTING. Front is non-head (BODY/TAIL) → pop and discard, drop_cnt+1, stay IDLE. Empty → stay.
  - ROUTING: register sw_route from front head → WAITING.
  - WAITING: sw_req=1; sw_ack=1 → ACTIVE.
  - ACTIVE: out_flit = FIFO front with valid=1 when FIFO non-empty; pop on out_ready. Popped flit type TAIL_FLIT → IDLE. Empty mid-packet: out_flit.valid=0, stay ACTIVE.
- out_flit is all-zero outside ACTIVE. Head flit is forwarded unmodified.
- drop_cnt saturates at 255.
- FIFO: read/write pointers with one extra wrap bit; full = same index, different wrap bit. Simultaneous push and pop when full is impossible (in_ready=0); when empty, push only.

## Timing
- Reset (async assert, sync-safe release): FIFO empty, in_ready=1, sw_req=0, sw_route=0, out_flit=0, gstate=IDLE, drop_cnt=0. Reset mid-packet discards FIFO contents and any pending request.
- Write-to-front latency: 1 cycle.
- Head written cycle t (empty FIFO, IDLE): IDLE at t+1, ROUTING t+2, sw_req=1 from t+3; sw_ack at t+3 → head on out_flit at t+4. Each extra cycle without sw_ack delays by one.
- ACTIVE throughput: 1 flit/cycle while out_ready=1 and FIFO non-empty.
- After tail pop in cycle c: IDLE at c+1; next head may enter ROUTING at c+2.
- sw_req deasserts the cycle after sw_ack is sampled high.

## Structure
- Add to router_pkg: route encodings ROUTE_NORTH=0, ROUTE_EAST=1, ROUTE_SOUTH=2, ROUTE_WEST=3, ROUTE_LOCAL=4 (ROUTE_t); function xy_route(xaddr, yaddr, cur_x, cur_y) returning ROUTE_t.
- Sub-module router_flit_fifo (parameter DEPTH, FLIT_t data, push/pop/full/empty, async active-high reset on clk/rst). FSM, route register and drop counter live in router_input_port.

## Test plan
- ROUTER_X=2, ROUTER_Y=2; head x=5,y=1 + 2 body + tail back-to-back, sw_ack tied 1, out_ready=1 → sw_route=1 (EAST), head out 4 cycles after write, 4 flits consecutive, gstate returns IDLE.
- Heads to (2,2), (0,9), (2,0), (2,7) → sw_route = 4, 3, 2, 0 respectively.
- sw_ack held 0 for 10 cycles after sw_req → sw_req and sw_route stable, out_flit.valid=0; 9 flits pushed → in_ready=0 after 8th, 9th held upstream.
- Body then tail flit with no head, then valid NONE_FLIT → all discarded, drop_cnt=3, no sw_req.
- out_ready toggled 1/0 during ACTIVE and upstream gap mid-packet → flits delivered in order, no duplicates, valid=0 while empty.
- rst pulsed while ACTIVE with 2 flits buffered → all outputs at reset values immediately, next head routed normally.
